alu_result_stage: RTL
=====================

Name: alu_result_stage

Overview:
- Downstream stage of the 8-bit bitwise op units (and/or/xor/not).
- Takes all four 9-bit op results, selects one by opcode and derives flags.
- Buffers result plus flags in a small FIFO with a valid/ready handshake toward the register-file/display stage.
- Decouples combinational op units from a consumer that may stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream offers an operation this cycle.
- in_ready  output  1  stage can accept; equals !full.
- in_op  input  2  opcode select: 0 AND, 1 OR, 2 XOR, 3 NOT.
- res_and, res_or, res_xor, res_not  input  9 each  op-unit results; bit 8 is carry.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  consumer takes the head entry.
- out_data  output  8  head result bits [7:0].
- out_carry  output  1  head result bit 8.
- out_zero  output  1  head result [7:0] == 0.
- out_neg  output  1  head result bit 7.
- occupancy  output  AW+1  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): pointers, occupancy and all storage cleared.
  - in_ready=1, out_valid=0, out_data=0, all flags 0.
  - Entries in flight are discarded. A transfer in the cycle of reset assertion is lost.
- Push: when in_valid && in_ready at a rising edge, write the selected result and its flags into the tail entry.
  - Flags are computed at push time, not at read time.
- Pop: when out_valid && out_ready at a rising edge, advance the head.
- Latency: an accepted item appears on out_* the next cycle at the earliest. No combinational path from in_* to out_*.
- out_valid = (occupancy != 0).
  - out_* always reflect the head entry.
  - When empty, out_data and flags are driven 0.
- Full (occupancy == DEPTH): in_ready=0. A push is refused even if a pop occurs in the same cycle (no same-cycle bypass). in_ready rises the cycle after a pop.
- Empty: an out_ready assertion is ignored and the head does not move.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. occupancy saturates by construction and never exceeds DEPTH.
- Data under backpressure: while out_valid && !out_ready, out_data and flags are held stable.
- in_op is sampled only on a push. Its value at other times is don't-care.
- All four opcodes are legal. res_* inputs not selected are ignored.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined: adds output out_parity (1 bit) = XOR reduction of the head result [7:0].
  - Stored per entry at push time.
  - Driven 0 when empty or in reset.
- Undefined: port and storage absent; all other behaviour identical.

Decomposition:
- Shared header alu_defs.vh:
  - opcode constants OP_AND=2'd0, OP_OR=2'd1, OP_XOR=2'd2, OP_NOT=2'd3;
  - flag bit positions within a stored entry (carry, zero, neg, parity);
  - entry width constant.
- One natural sub-module, alu_result_fifo: generic parameterised synchronous FIFO carrying the packed entry, with push/pop/full/empty/occupancy.
- The top level holds the opcode mux and flag generation.

Test Plan:
- Reset then single op: in_op=0, res_and=9'h00C, push, out_ready=1.
  - Next cycle: out_valid=1, out_data=8'h0C, zero=0, neg=0, carry=0.
  - Following cycle: out_valid=0.
- Flag corners, pushed back-to-back (in_op=1, 2, 3):
  - res_or=9'h080 → neg=1.
  - res_xor=9'h000 → zero=1.
  - res_not=9'h1FF → carry=1, data=8'hFF, neg=1.
  - All three pop in order with correct flags.
- Fill to full with DEPTH=4, out_ready=0, five pushes offered.
  - Fourth push leaves occupancy=4, in_ready=0; fifth value is not accepted.
  - Draining returns the first four values in order.
- Full with simultaneous pop and in_valid: push refused that cycle.
  - occupancy goes 4→3; in_ready=1 the next cycle; the pending value is then accepted.
- Steady streaming with in_valid=1 and out_ready=1 for 20 cycles of incrementing res_xor:
  - occupancy stays at 1 after the first cycle; all 20 values emerge in order.
- Reset mid-operation with occupancy=3 and asynchronous rst pulse:
  - out_valid drops immediately, occupancy=0, in_ready=1.
  - With ALU_RESULT_PARITY_EN: 8'h07 → parity=1, 8'h03 → parity=0.

Source files
------------

// File: rtl/alu_result_stage_pkg.sv
// Shared opcode constants, entry layout and flag generation for alu_result_stage.
// Optional parity bit in each entry is controlled by ALU_RESULT_PARITY_EN.
package alu_result_stage_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_NOT = 2'd3;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned RES_W  = DATA_W + 1;

  // Stored entry: flags sit above the data byte, parity (if present) on top.
  typedef struct packed {
`ifdef ALU_RESULT_PARITY_EN
    logic              parity;
`endif
    logic              neg;
    logic              zero;
    logic              carry;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  // Flags are derived once, when the result is captured.
  function automatic entry_t make_entry(input logic [RES_W-1:0] res);
    entry_t e;
    e.data  = res[DATA_W-1:0];
    e.carry = res[DATA_W];
    e.zero  = (res[DATA_W-1:0] == DATA_W'(0));
    e.neg   = res[DATA_W-1];
`ifdef ALU_RESULT_PARITY_EN
    e.parity = ^res[DATA_W-1:0];
`endif
    return e;
  endfunction

endpackage

// File: rtl/alu_result_stage_fifo.sv
// alu_result_fifo: generic synchronous FIFO with occupancy count and zeroed read data when empty.
module alu_result_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == (AW+1)'(0));
  // No bypass: a full FIFO refuses a push even when popping the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = empty ? W'(0) : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      count  <= (AW+1)'(0);
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= W'(0);
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Selects one of four bitwise op results, derives flags and buffers them toward a stallable consumer.
// Define ALU_RESULT_PARITY_EN to add the out_parity output.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [RES_W-1:0] res_and,
  input  logic [RES_W-1:0] res_or,
  input  logic [RES_W-1:0] res_xor,
  input  logic [RES_W-1:0] res_not,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic [AW:0]      occupancy
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic [RES_W-1:0]   sel_res;
  entry_t             wr_entry;
  entry_t             head;
  logic [ENTRY_W-1:0] rd_bits;
  logic               full;
  logic               empty;

  // Opcode mux; unselected results are ignored.
  always_comb begin
    sel_res = res_and;
    case (in_op)
      OP_AND:  sel_res = res_and;
      OP_OR:   sel_res = res_or;
      OP_XOR:  sel_res = res_xor;
      OP_NOT:  sel_res = res_not;
      default: sel_res = res_and;
    endcase
  end

  assign wr_entry = make_entry(sel_res);

  alu_result_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (in_valid),
    .wr_data (wr_entry),
    .pop     (out_ready),
    .rd_data (rd_bits),
    .full    (full),
    .empty   (empty),
    .count   (occupancy)
  );

  assign head      = entry_t'(rd_bits);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = head.data;
  assign out_carry = head.carry;
  assign out_zero  = head.zero;
  assign out_neg   = head.neg;
`ifdef ALU_RESULT_PARITY_EN
  assign out_parity = head.parity;
`endif

endmodule
